// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: load-use stall, branch flush and ID-operand forwarding for a 5-stage RV32I pipeline.
// Define HAZARD_STATS_EN to add saturating stall_cnt/flush_cnt statistics counters.
module hazard_forward_unit #(
    parameter int REG_AW = 5
`ifdef HAZARD_STATS_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rs1use,
    input  logic              rs2use,
    input  logic [1:0]        hazard_optype_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic              Branch_ID,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_FD_flush,
    output logic              reg_DE_flush,
    output logic [1:0]        forward_ctrl_A,
    output logic [1:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls
`ifdef HAZARD_STATS_EN
    , output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);
    localparam logic [1:0] OP_ALU = 2'b01, OP_LOAD = 2'b10, OP_STORE = 2'b11;

    logic [1:0]        ex_optype_q, ex_optype_d, mem_optype_q, mem_optype_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
    logic              ls_ex_q, ls_ex_d, fwd_ls_q, fwd_ls_d;
    logic              ex_alu, ex_load, mem_alu, mem_load;
    logic              ld_hit1, ld_hit2, exempt, stall;

    // An EX load hit selects 00: the consumer is either stalled or a store covered by forward_ctrl_ls.
    function automatic logic [1:0] fwd_sel(input logic use_r, input logic [REG_AW-1:0] rs,
                                           input logic [REG_AW-1:0] erd, input logic [REG_AW-1:0] mrd,
                                           input logic e_alu, input logic e_ld,
                                           input logic m_alu, input logic m_ld);
        return !use_r                ? 2'b00 :
               (e_ld && rs == erd)   ? 2'b00 :
               (e_alu && rs == erd)  ? 2'b01 :
               (m_alu && rs == mrd)  ? 2'b10 :
               (m_ld && rs == mrd)   ? 2'b11 : 2'b00;
    endfunction

    always_comb begin
        ex_alu          = ex_optype_q == OP_ALU && ex_rd_q != '0;
        ex_load         = ex_optype_q == OP_LOAD && ex_rd_q != '0;
        mem_alu         = mem_optype_q == OP_ALU && mem_rd_q != '0;
        mem_load        = mem_optype_q == OP_LOAD && mem_rd_q != '0;
        ld_hit1         = rs1use && ex_load && rs1_ID == ex_rd_q;
        ld_hit2         = rs2use && ex_load && rs2_ID == ex_rd_q;
        exempt          = hazard_optype_ID == OP_STORE && ld_hit2 && !ld_hit1;
        stall           = !rst && (ld_hit1 || ld_hit2) && !exempt;
        PC_EN_IF        = !stall;
        reg_FD_EN       = !stall;
        reg_DE_flush    = stall;
        reg_FD_flush    = !rst && Branch_ID && !stall;
        forward_ctrl_A  = rst ? 2'b00 : fwd_sel(rs1use, rs1_ID, ex_rd_q, mem_rd_q, ex_alu, ex_load, mem_alu, mem_load);
        forward_ctrl_B  = rst ? 2'b00 : fwd_sel(rs2use, rs2_ID, ex_rd_q, mem_rd_q, ex_alu, ex_load, mem_alu, mem_load);
        forward_ctrl_ls = !rst && fwd_ls_q;
        mem_optype_d    = ex_optype_q;
        mem_rd_d        = ex_rd_q;
        ex_optype_d     = stall ? 2'b00 : hazard_optype_ID;
        ex_rd_d         = stall ? '0 : rd_ID;
        ls_ex_d         = !stall && exempt;
        fwd_ls_d        = ls_ex_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_optype_q  <= '0;
            ex_rd_q      <= '0;
            mem_optype_q <= '0;
            mem_rd_q     <= '0;
            ls_ex_q      <= 1'b0;
            fwd_ls_q     <= 1'b0;
        end else begin
            ex_optype_q  <= ex_optype_d;
            ex_rd_q      <= ex_rd_d;
            mem_optype_q <= mem_optype_d;
            mem_rd_q     <= mem_rd_d;
            ls_ex_q      <= ls_ex_d;
            fwd_ls_q     <= fwd_ls_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (reg_FD_flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule
